ahb_manager_lite: RTL and testbench

//  AHB-Lite manager (initiator) used to drive the USB endpoint's AHB-Lite register interface.

---
 rtl/ahb_manager_lite_if.sv | 45 ++++
 rtl/ahb_manager_lite.sv | 169 ++++++++++++++++
 tb/tb_ahb_manager_lite.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_manager_lite_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_manager_lite_if
// Description : Command/response port and AHB-Lite bus bundle for ahb_manager_lite
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_manager_lite_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [1:0]            cmd_size;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            hsize;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hresp;
    logic                  hready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  hrdata, hresp, hready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output hsel, haddr, hsize, htrans, hwrite, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output hrdata, hresp, hready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  hsel, haddr, hsize, htrans, hwrite, hwdata
    );
endinterface
`default_nettype wire

// File: rtl/ahb_manager_lite.sv
`default_nettype none
// ============================================================================
// Module      : ahb_manager_lite
// Description : Single-outstanding AHB-Lite manager, one NONSEQ per command
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_manager_lite #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  wire logic           clk,
    input  wire logic           n_rst,
    ahb_manager_lite_if.master  bus
);

    localparam int                 c_CNT_W       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX     = '1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);
    localparam logic               c_TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [1:0]         c_HTRANS_IDLE = 2'b00;
    localparam logic [1:0]         c_HTRANS_NSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_hsel;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_hsize;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_rsp_timeout;

    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_timeout;

    // Saturating increment so a huge stall can never wrap back under the limit
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = c_TIMEOUT_EN && (w_cnt_inc == c_TIMEOUT_CNT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_hsel        <= 1'b0;
            r_haddr       <= '0;
            r_hsize       <= 2'b00;
            r_htrans      <= c_HTRANS_IDLE;
            r_hwrite      <= 1'b0;
            r_hwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= bus.cmd_write;
                        r_wdata     <= bus.cmd_wdata;
                        r_hsel      <= 1'b1;
                        r_htrans    <= c_HTRANS_NSEQ;
                        r_haddr     <= bus.cmd_addr;
                        r_hsize     <= bus.cmd_size;
                        r_hwrite    <= bus.cmd_write;
                        r_state     <= S_ADDR;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                S_ADDR: begin
                    if (bus.hready) begin
                        r_hsel   <= 1'b0;
                        r_htrans <= c_HTRANS_IDLE;
                        r_haddr  <= '0;
                        r_hsize  <= 2'b00;
                        r_hwrite <= 1'b0;
                        r_hwdata <= r_wdata;
                        r_cnt    <= '0;
                        r_state  <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bus.hresp) begin
                        if (bus.hready) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_hwdata    <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end else if (bus.hready) begin
                        r_rsp_valid <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_hwdata    <= '0;
                        if (!r_write) begin
                            r_rsp_rdata <= bus.hrdata;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Subordinate never answered: abandon the bus, report as error
                        if (w_timeout) begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_error   <= 1'b1;
                            r_rsp_timeout <= 1'b1;
                            r_cmd_ready   <= 1'b1;
                            r_hwdata      <= '0;
                            r_state       <= S_IDLE;
                        end
                    end
                end

                S_ERR: begin
                    if (bus.hready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_hwdata    <= '0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.hsel        = r_hsel;
    assign bus.haddr       = r_haddr;
    assign bus.hsize       = r_hsize;
    assign bus.htrans      = r_htrans;
    assign bus.hwrite      = r_hwrite;
    assign bus.hwdata      = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_manager_lite.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_manager_lite
// Description : Directed-vector bench for ahb_manager_lite (TIMEOUT = 16)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_manager_lite;

    logic clk;
    logic n_rst;
    int   vectors;
    int   miscompares;

    ahb_manager_lite_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    ahb_manager_lite #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32),
        .TIMEOUT    (16)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [3:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_size  = size;
        bus.cmd_wdata = wdata;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.cmd_ready, bus.hsel, bus.htrans, bus.hwrite, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {bus.cmd_ready, bus.hsel, bus.htrans, bus.hwrite, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout});
        end
        vectors++;
        if ({bus.haddr, bus.hsize, bus.hwdata, bus.rsp_rdata} !== 70'h0) begin
            miscompares++;
            $display("FAIL reset_data haddr=%h hsize=%h hwdata=%h rdata=%h exp=0", bus.haddr, bus.hsize, bus.hwdata, bus.rsp_rdata);
        end
        n_rst = 1'b1;
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait;
        issue(1'b1, 4'h0, 2'd2, 32'hDEADBEEF);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 32'h0BAD_0BAD;
        vectors++;
        if ({bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite, bus.cmd_ready} !== {1'b1, 2'b10, 4'h0, 2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_addr_phase got=%b exp=%b", {bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite, bus.cmd_ready},
                     {1'b1, 2'b10, 4'h0, 2'd2, 1'b1, 1'b0});
        end
        tick();
        vectors++;
        if ({bus.hsel, bus.htrans, bus.rsp_valid} !== 4'b0000 || bus.hwdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_data_phase hsel/htrans/rsp=%b hwdata=%h exp=0000/deadbeef",
                     {bus.hsel, bus.htrans, bus.rsp_valid}, bus.hwdata);
        end
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready} !== 4'b1001) begin
            miscompares++;
            $display("FAIL wr_rsp got=%b exp=1001", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready});
        end
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rsp_pulse got=%b exp=0", bus.rsp_valid);
        end
    endtask

    task automatic test_read_wait;
        issue(1'b0, 4'h8, 2'd0, 32'h1234_5678);
        tick();
        bus.cmd_valid = 1'b0;
        vectors++;
        if ({bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite} !== {1'b1, 2'b10, 4'h8, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_addr_phase got=%b exp=%b", {bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite},
                     {1'b1, 2'b10, 4'h8, 2'd0, 1'b0});
        end
        tick();
        bus.hready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (bus.rsp_valid !== 1'b0 || bus.hwdata !== 32'h1234_5678 || bus.cmd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_wait%0d rsp=%b hwdata=%h ready=%b exp=0/12345678/0", i, bus.rsp_valid, bus.hwdata, bus.cmd_ready);
            end
        end
        bus.hready = 1'b1;
        bus.hrdata = 32'h0000_00A5;
        tick();
        bus.hrdata = 32'hFFFF_FFFF;
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 3'b100 || bus.rsp_rdata !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL rd_rsp flags=%b rdata=%h exp=100/000000a5", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}, bus.rsp_rdata);
        end
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL rd_rdata_hold rsp=%b rdata=%h exp=0/000000a5", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_error_two_cycle;
        issue(1'b1, 4'h4, 2'd2, 32'hCAFE_0001);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.hresp  = 1'b1;
        bus.hready = 1'b0;
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.htrans, bus.cmd_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL err_first got=%b exp=0000", {bus.rsp_valid, bus.htrans, bus.cmd_ready});
        end
        bus.hready = 1'b1;
        tick();
        bus.hresp = 1'b0;
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready} !== 4'b1101) begin
            miscompares++;
            $display("FAIL err_rsp got=%b exp=1101", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready});
        end
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error, bus.cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL err_after got=%b exp=001", {bus.rsp_valid, bus.rsp_error, bus.cmd_ready});
        end
    endtask

    task automatic test_error_one_cycle;
        issue(1'b0, 4'hC, 2'd1, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.hresp  = 1'b1;
        bus.hrdata = 32'h5555_5555;
        tick();
        bus.hresp = 1'b0;
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 3'b110) begin
            miscompares++;
            $display("FAIL err1_rsp got=%b exp=110", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout});
        end
        tick();
    endtask

    task automatic test_timeout;
        issue(1'b0, 4'h2, 2'd2, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.hready = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            vectors++;
            if (bus.rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL to_early wait=%0d rsp=%b exp=0", i, bus.rsp_valid);
            end
        end
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready} !== 4'b1111) begin
            miscompares++;
            $display("FAIL to_rsp got=%b exp=1111", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready});
        end
        tick();
        bus.hready = 1'b1;
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 3'b000) begin
            miscompares++;
            $display("FAIL to_after got=%b exp=000", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout});
        end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 4'h4, 2'd2, 32'h1111_1111);
        tick();
        bus.cmd_addr  = 4'hC;
        bus.cmd_wdata = 32'h2222_2222;
        tick();
        vectors++;
        if (bus.hwdata !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL b2b_hwdata1 got=%h exp=11111111", bus.hwdata);
        end
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.htrans, bus.hsel} !== 5'b11000) begin
            miscompares++;
            $display("FAIL b2b_gap got=%b exp=11000", {bus.rsp_valid, bus.cmd_ready, bus.htrans, bus.hsel});
        end
        tick();
        bus.cmd_valid = 1'b0;
        vectors++;
        if ({bus.htrans, bus.hsel, bus.haddr, bus.rsp_valid, bus.cmd_ready} !== {2'b10, 1'b1, 4'hC, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_second got=%b exp=%b", {bus.htrans, bus.hsel, bus.haddr, bus.rsp_valid, bus.cmd_ready},
                     {2'b10, 1'b1, 4'hC, 1'b0, 1'b0});
        end
        tick();
        vectors++;
        if (bus.hwdata !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL b2b_hwdata2 got=%h exp=22222222", bus.hwdata);
        end
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_rsp2 got=%b exp=10", {bus.rsp_valid, bus.rsp_error});
        end
        tick();
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 4'h6, 2'd2, 32'hABCD_0000);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.hready = 1'b0;
        tick();
        n_rst = 1'b0;
        #1;
        vectors++;
        if ({bus.cmd_ready, bus.hsel, bus.htrans, bus.rsp_valid, bus.rsp_error} !== 6'b0 || bus.hwdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_out ctrl=%b hwdata=%h exp=000000/0",
                     {bus.cmd_ready, bus.hsel, bus.htrans, bus.rsp_valid, bus.rsp_error}, bus.hwdata);
        end
        bus.hready = 1'b1;
        tick();
        n_rst = 1'b1;
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.hsel} !== 3'b010) begin
            miscompares++;
            $display("FAIL rstmid_idle got=%b exp=010", {bus.rsp_valid, bus.cmd_ready, bus.hsel});
        end
        issue(1'b0, 4'hA, 2'd2, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        bus.hrdata    = 32'h600D_F00D;
        tick();
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_error} !== 2'b10 || bus.rsp_rdata !== 32'h600D_F00D) begin
            miscompares++;
            $display("FAIL rstmid_next flags=%b rdata=%h exp=10/600df00d", {bus.rsp_valid, bus.rsp_error}, bus.rsp_rdata);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        n_rst         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h0;
        bus.cmd_size  = 2'd0;
        bus.cmd_wdata = 32'h0;
        bus.hrdata    = 32'h0;
        bus.hresp     = 1'b0;
        bus.hready    = 1'b1;

        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_error_two_cycle();
        test_error_one_cycle();
        test_timeout();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
